// File: rtl/odd_count_sched.sv
// Round-robin scheduler sharing one odd up-counter between two requesters; bursts of N odd values with valid/ready.
// Optional: define ODD_SCHED_RESTART_EN to restart the counter at 1 on every grant.
module odd_count_sched #(
  parameter int WIDTH = 3,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             owner,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  // Only the upper bits are stored; the LSB is hard-wired to 1 so dout can never be even.
  logic [WIDTH-2:0]   cnt_hi_q, cnt_hi_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic               done_q, done_d;

  logic               grab;
  logic               beat;
  logic               last_beat;
  logic               winner;
  logic [LEN_W-1:0]   win_len;

  assign grab      = (state_q == IDLE) && (req != 2'b00);
  assign beat      = (state_q == RUN) && dout_ready;
  assign last_beat = beat && (remaining_q == LEN_W'(1));

  // On a tie the requester that did not own the previous burst wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner_q;
      default: winner = 1'b0;
    endcase
  end

  assign win_len = winner ? len1 : len0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grab) state_d = RUN;
      RUN:     if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt        = 2'b00;
    dout_valid = 1'b0;
    if (state_q == RUN) begin
      gnt[owner_q] = 1'b1;
      dout_valid   = 1'b1;
    end
  end

  assign dout  = {cnt_hi_q, 1'b1};
  assign owner = owner_q;
  assign done  = done_q;

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    remaining_d  = remaining_q;
    cnt_hi_d     = cnt_hi_q;
    done_d       = last_beat;
    if (grab) begin
      owner_d      = winner;
      last_owner_d = winner;
      remaining_d  = (win_len == '0) ? LEN_W'(1) : win_len;
`ifdef ODD_SCHED_RESTART_EN
      cnt_hi_d     = '0;
`endif
    end else if (beat) begin
      remaining_d = remaining_q - 1'b1;
      cnt_hi_d    = cnt_hi_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_hi_q     <= '0;
      remaining_q  <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      cnt_hi_q     <= cnt_hi_d;
      remaining_q  <= remaining_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_odd_count_sched.sv
// Self-checking bench for odd_count_sched: directed scenarios plus randomized traffic against a behavioural model.
module tb_odd_count_sched;

  localparam int WIDTH = 3;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [LEN_W-1:0] len0 = '0;
  logic [LEN_W-1:0] len1 = '0;
  logic [1:0]       gnt;
  logic             owner;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b1;
  logic             done;

  odd_count_sched #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
    .gnt(gnt), .owner(owner), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .done(done)
  );

  always #5 clk = ~clk;

  // Model: dout is simply the (beats accepted so far)-th odd number modulo 2^WIDTH.
  bit m_busy;
  int m_own, m_last, m_rem, m_beats;
  bit m_done;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_own = 0; m_last = 1; m_rem = 0; m_beats = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (req != 2'b00) begin
          int w;
          w = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : 1 - m_last;
          m_busy = 1; m_own = w; m_last = w;
          m_rem = (w == 1) ? int'(len1) : int'(len0);
          if (m_rem == 0) m_rem = 1;
`ifdef ODD_SCHED_RESTART_EN
          m_beats = 0;
`endif
        end
      end else if (dout_ready) begin
        m_beats++;
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;
  int beat_q[$];
  int done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle_check();
    if (chk_en) begin
      chk("gnt", int'(gnt), m_busy ? (1 << m_own) : 0);
      chk("dout_valid", int'(dout_valid), int'(m_busy));
      chk("dout", int'(dout), (2 * m_beats + 1) % (1 << WIDTH));
      chk("owner", int'(owner), m_own);
      chk("done", int'(done), int'(m_done));
    end
  endtask

  // One cycle: check and log at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    cycle_check();
    if (reset === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1)
      beat_q.push_back(int'(owner) * 256 + int'(dout));
    if (reset === 1'b1 && done === 1'b1)
      done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input string nm, input int base, input int n, input int bound);
    int k;
    k = 0;
    while (beat_q.size() - base < n && k < bound) begin
      tick();
      k++;
    end
    chk({nm, "_beats_seen"}, int'(beat_q.size() - base >= n), 1);
  endtask

  task automatic chk_log(input string nm, input int base, input int exp[8], input int n);
    chk({nm, "_count"}, beat_q.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < beat_q.size())
        chk($sformatf("%s_beat%0d", nm, i), beat_q[base + i], exp[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 2'b00; dout_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
  endtask

  int b, d;

  initial begin
    // Reset state
    reset = 1'b0;
    #1;
    tick();
    chk_en = 1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_dout", int'(dout), 1);
    tick();
    reset = 1'b1;

    // Single request, no backpressure
    b = beat_q.size(); d = done_cnt;
    req = 2'b01; len0 = 4'd3;
    tick();
    chk("t1_gnt", int'(gnt), 1);
    chk("t1_owner", int'(owner), 0);
    req = 2'b00;
    wait_beats("t1", b, 3, 20);
    repeat (3) tick();
    chk_log("t1", b, '{1, 3, 5, 0, 0, 0, 0, 0}, 3);
    chk("t1_done_cnt", done_cnt - d, 1);
    chk("t1_rest_dout", int'(dout), 7);

    // Tie and round-robin
    do_reset();
    b = beat_q.size(); d = done_cnt;
    req = 2'b11; len0 = 4'd2; len1 = 4'd2;
    wait_beats("t2", b, 6, 40);
    req = 2'b00;
    repeat (3) tick();
`ifdef ODD_SCHED_RESTART_EN
    chk_log("t2", b, '{1, 3, 257, 259, 1, 3, 0, 0}, 6);
`else
    chk_log("t2", b, '{1, 3, 261, 263, 1, 3, 0, 0}, 6);
`endif
    chk("t2_done_cnt", done_cnt - d, 3);

    // Wrap and zero length
    do_reset();
    b = beat_q.size();
    req = 2'b01; len0 = 4'd6;
    tick();
    req = 2'b00;
    wait_beats("t3", b, 6, 30);
    repeat (2) tick();
    chk_log("t3", b, '{1, 3, 5, 7, 1, 3, 0, 0}, 6);
    b = beat_q.size();
    req = 2'b10; len1 = 4'd0;
    tick();
    req = 2'b00;
    repeat (4) tick();
`ifdef ODD_SCHED_RESTART_EN
    chk_log("t3z", b, '{257, 0, 0, 0, 0, 0, 0, 0}, 1);
`else
    chk_log("t3z", b, '{261, 0, 0, 0, 0, 0, 0, 0}, 1);
`endif

    // Backpressure after the first beat
    do_reset();
    b = beat_q.size();
    req = 2'b01; len0 = 4'd4; dout_ready = 1'b1;
    tick();
    req = 2'b00;
    tick();
    dout_ready = 1'b0;
    tick();
    chk("t4_hold1_dout", int'(dout), 3);
    chk("t4_hold1_valid", int'(dout_valid), 1);
    tick();
    chk("t4_hold2_dout", int'(dout), 3);
    chk("t4_hold2_valid", int'(dout_valid), 1);
    dout_ready = 1'b1;
    wait_beats("t4", b, 4, 20);
    repeat (2) tick();
    chk_log("t4", b, '{1, 3, 5, 7, 0, 0, 0, 0}, 4);

    // Reset mid-burst
    do_reset();
    b = beat_q.size(); d = done_cnt;
    req = 2'b01; len0 = 4'd5;
    tick();
    req = 2'b00;
    tick(); tick();
    chk("t5_two_beats", beat_q.size() - b, 2);
    reset = 1'b0;
    #1;
    chk("t5_gnt", int'(gnt), 0);
    chk("t5_valid", int'(dout_valid), 0);
    chk("t5_dout", int'(dout), 1);
    chk("t5_done", int'(done), 0);
    tick();
    chk("t5_no_done", done_cnt - d, 0);
    reset = 1'b1; req = 2'b11; len0 = 4'd2; len1 = 4'd2;
    b = beat_q.size();
    wait_beats("t5", b, 1, 10);
    req = 2'b00;
    chk_log("t5", b, '{1, 0, 0, 0, 0, 0, 0, 0}, 1);
    repeat (4) tick();

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      tick();
      req = 2'($urandom_range(0, 3));
      len0 = LEN_W'($urandom_range(0, 15));
      len1 = LEN_W'($urandom_range(0, 15));
      dout_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) != 0);
    end
    reset = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
